// File: rtl/pc_next_pkg.sv
// pc_next_pkg: shared types and defaults for the next-PC source stage.
//   op_e            : command encoding carried on op_code (5-7 decode as NONE)
//   ADDR_W_DEFAULT  : default program address width
//   DEPTH_DEFAULT   : default return-address stack depth
//   INT_VEC_DEFAULT : default interrupt vector address
// Optional build macro used by the RAS: PC_NEXT_RAS_WRAP_EN.
package pc_next_pkg;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_JUMP = 3'd1,
      OP_CALL = 3'd2,
      OP_RET  = 3'd3,
      OP_INT  = 3'd4
   } op_e;

   localparam int          ADDR_W_DEFAULT  = 10;
   localparam int          DEPTH_DEFAULT   = 8;
   localparam logic [9:0]  INT_VEC_DEFAULT = 10'h3FF;

endpackage

// File: rtl/pc_next_unit_if.sv
// pc_next_unit_if: command and result bundle between the control FSM and
// the next-PC stage.
//   op_valid/op_code/pc_cur/branch_addr : command from the control FSM
//   next_pc/pc_ld                       : PC register load data and strobe
//   ras_empty/ras_full/ras_depth/ras_err: return-address stack status
// Handshake: op_valid is a one-cycle strobe with no ready signal; every op
// presented with op_valid=1 is accepted on that rising edge, and its pc_ld
// pulse appears in the following cycle. Back-to-back strobes are legal.
// Modports: master = control FSM side, slave = pc_next_unit.
interface pc_next_unit_if #(
   parameter int ADDR_W = pc_next_pkg::ADDR_W_DEFAULT,
   parameter int DEPTH  = pc_next_pkg::DEPTH_DEFAULT
) ();

   logic                       op_valid;
   logic [2:0]                 op_code;
   logic [ADDR_W-1:0]          pc_cur;
   logic [ADDR_W-1:0]          branch_addr;
   logic [ADDR_W-1:0]          next_pc;
   logic                       pc_ld;
   logic                       ras_empty;
   logic                       ras_full;
   logic [$clog2(DEPTH):0]     ras_depth;
   logic                       ras_err;

   modport master (
      output op_valid, op_code, pc_cur, branch_addr,
      input  next_pc, pc_ld, ras_empty, ras_full, ras_depth, ras_err
   );

   modport slave (
      input  op_valid, op_code, pc_cur, branch_addr,
      output next_pc, pc_ld, ras_empty, ras_full, ras_depth, ras_err
   );

endinterface

// File: rtl/pc_next_unit_ras_stack.sv
// ras_stack: return-address stack with registered status flags.
//   clk, rst   : clock, synchronous active-high reset
//   push, pop  : one operation per cycle (push wins if both are asserted)
//   push_data  : value to push
//   pop_data   : current top of stack, 0 when empty (valid in the pop cycle)
//   depth      : entry count, empty/full derived from it, err is sticky
// Build macro PC_NEXT_RAS_WRAP_EN: when defined, a push on a full stack
// overwrites the oldest entry instead of being dropped and flagged.
module ras_stack #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [ADDR_W-1:0]        push_data,
   output logic [ADDR_W-1:0]        pop_data,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     empty,
   output logic                     full,
   output logic                     err
);

   localparam int PW = $clog2(DEPTH);
   localparam int DW = PW + 1;
   localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];
   // ptr is the write slot; it wraps modulo DEPTH, so when the stack is
   // full it points at the oldest entry, which is what wrap mode replaces.
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     top_idx;
   logic [DW-1:0]     depth_q, depth_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              err_q, err_d;

   assign top_idx  = ptr_q - PW'(1);
   assign pop_data = empty_q ? '0 : mem_q[top_idx];

   always_comb begin
      mem_d   = mem_q;
      ptr_d   = ptr_q;
      depth_d = depth_q;
      err_d   = err_q;
      if (push) begin
         if (!full_q) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            depth_d      = depth_q + DW'(1);
         end else begin
`ifdef PC_NEXT_RAS_WRAP_EN
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
`else
            err_d        = 1'b1;
`endif
         end
      end else if (pop) begin
         if (!empty_q) begin
            ptr_d   = top_idx;
            depth_d = depth_q - DW'(1);
         end else begin
            err_d   = 1'b1;
         end
      end
      empty_d = (depth_d == '0);
      full_d  = (depth_d == DEPTH_C);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         depth_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         depth_q <= depth_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         err_q   <= err_d;
      end
   end

   // Storage needs no reset: depth=0 makes every entry unreachable.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign depth = depth_q;
   assign empty = empty_q;
   assign full  = full_q;
   assign err   = err_q;

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC source stage feeding the PC register's parallel load.
// Decodes JUMP/CALL/RET/INT into one registered load target plus a one-cycle
// load strobe, and keeps return addresses in an internal stack.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pc_next_unit_if.slave (op_valid, op_code, pc_cur, branch_addr
//              in; next_pc, pc_ld, ras_empty, ras_full, ras_depth, ras_err out)
// Build macro PC_NEXT_RAS_WRAP_EN selects circular RAS overflow behaviour.
module pc_next_unit
   import pc_next_pkg::*;
#(
   parameter int                ADDR_W  = ADDR_W_DEFAULT,
   parameter int                DEPTH   = DEPTH_DEFAULT,
   parameter logic [ADDR_W-1:0] INT_VEC = ADDR_W'(INT_VEC_DEFAULT)
) (
   input  logic           clk,
   input  logic           rst,
   pc_next_unit_if.slave  bus
);

   logic                    push, pop;
   logic [ADDR_W-1:0]       push_data, pop_data;
   logic [ADDR_W-1:0]       next_pc_q, next_pc_d;
   logic                    pc_ld_q, pc_ld_d;
   logic [$clog2(DEPTH):0]  ras_depth;
   logic                    ras_empty, ras_full, ras_err;

   always_comb begin
      push      = 1'b0;
      pop       = 1'b0;
      push_data = '0;
      next_pc_d = next_pc_q;
      pc_ld_d   = 1'b0;
      if (bus.op_valid) begin
         case (bus.op_code)
            OP_JUMP: begin
               next_pc_d = bus.branch_addr;
               pc_ld_d   = 1'b1;
            end
            OP_CALL: begin
               push      = 1'b1;
               push_data = bus.pc_cur + ADDR_W'(1);  // wraps at 2^ADDR_W
               next_pc_d = bus.branch_addr;
               pc_ld_d   = 1'b1;
            end
            OP_RET: begin
               pop       = 1'b1;
               next_pc_d = pop_data;                 // 0 on an empty stack
               pc_ld_d   = 1'b1;
            end
            OP_INT: begin
               push      = 1'b1;
               push_data = bus.pc_cur;               // resume address as given
               next_pc_d = INT_VEC;
               pc_ld_d   = 1'b1;
            end
            default: ;                               // NONE and reserved codes
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         next_pc_q <= '0;
         pc_ld_q   <= 1'b0;
      end else begin
         next_pc_q <= next_pc_d;
         pc_ld_q   <= pc_ld_d;
      end
   end

   ras_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .pop_data  (pop_data),
      .depth     (ras_depth),
      .empty     (ras_empty),
      .full      (ras_full),
      .err       (ras_err)
   );

   assign bus.next_pc   = next_pc_q;
   assign bus.pc_ld     = pc_ld_q;
   assign bus.ras_depth = ras_depth;
   assign bus.ras_empty = ras_empty;
   assign bus.ras_full  = ras_full;
   assign bus.ras_err   = ras_err;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed and randomized checks of pc_next_unit against a
// queue-based return-stack model.
module tb_pc_next_unit;
   import pc_next_pkg::*;

   localparam int AW    = 10;
   localparam int DEPTH = 8;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pc_next_unit_if #(.ADDR_W(AW), .DEPTH(DEPTH)) bus ();

   pc_next_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .INT_VEC(10'h3FF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // scoreboard / reference model
   int            n_checks = 0;
   int            n_pass   = 0;
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] exp_next;
   logic          exp_ld;
   logic          exp_err;

   task automatic model_push(input logic [AW-1:0] v);
      if (exp_q.size() < DEPTH) exp_q.push_back(v);
      else begin
`ifdef PC_NEXT_RAS_WRAP_EN
         void'(exp_q.pop_front());
         exp_q.push_back(v);
`else
         exp_err = 1'b1;
`endif
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      exp_next = '0;
      exp_ld   = 1'b0;
      exp_err  = 1'b0;
   endtask

   // driver: present one op at negedge, let one rising edge take it, return
   // at the following negedge with the model updated to match.
   task automatic drive_op(input logic valid, input logic [2:0] code,
                           input logic [AW-1:0] pc, input logic [AW-1:0] br);
      logic [AW-1:0] ret_addr;
      bus.op_valid    = valid;
      bus.op_code     = code;
      bus.pc_cur      = pc;
      bus.branch_addr = br;
      exp_ld = 1'b0;
      if (valid) begin
         case (code)
            3'd1: begin exp_next = br; exp_ld = 1'b1; end
            3'd2: begin ret_addr = pc + 10'd1; model_push(ret_addr); exp_next = br; exp_ld = 1'b1; end
            3'd3: begin
               if (exp_q.size() > 0) exp_next = exp_q.pop_back();
               else begin exp_next = '0; exp_err = 1'b1; end
               exp_ld = 1'b1;
            end
            3'd4: begin model_push(pc); exp_next = 10'h3FF; exp_ld = 1'b1; end
            default: ;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
      bus.op_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.op_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (bus.next_pc !== 10'h000) $display("FAIL reset_next_pc got=%h exp=000", bus.next_pc); else n_pass++;
      n_checks++; if (bus.pc_ld !== 1'b0) $display("FAIL reset_pc_ld got=%b exp=0", bus.pc_ld); else n_pass++;
      n_checks++; if (bus.ras_depth !== 4'd0) $display("FAIL reset_depth got=%0d exp=0", bus.ras_depth); else n_pass++;
      n_checks++; if (bus.ras_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.ras_empty); else n_pass++;
      n_checks++; if (bus.ras_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.ras_full); else n_pass++;
      n_checks++; if (bus.ras_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.ras_err); else n_pass++;
   endtask

   task automatic test_jump();
      drive_op(1'b1, OP_JUMP, 10'h000, 10'h123);
      n_checks++; if (bus.next_pc !== 10'h123) $display("FAIL jump_next_pc got=%h exp=123", bus.next_pc); else n_pass++;
      n_checks++; if (bus.pc_ld !== 1'b1) $display("FAIL jump_pc_ld got=%b exp=1", bus.pc_ld); else n_pass++;
      n_checks++; if (bus.ras_empty !== 1'b1) $display("FAIL jump_empty got=%b exp=1", bus.ras_empty); else n_pass++;
      drive_op(1'b0, OP_JUMP, 10'h000, 10'h2AA);
      n_checks++; if (bus.pc_ld !== 1'b0) $display("FAIL jump_pc_ld_drop got=%b exp=0", bus.pc_ld); else n_pass++;
      n_checks++; if (bus.next_pc !== 10'h123) $display("FAIL jump_next_pc_hold got=%h exp=123", bus.next_pc); else n_pass++;
   endtask

   task automatic test_call_ret();
      do_reset();
      drive_op(1'b1, OP_CALL, 10'h010, 10'h200);
      n_checks++; if (bus.next_pc !== 10'h200) $display("FAIL call_next_pc got=%h exp=200", bus.next_pc); else n_pass++;
      n_checks++; if (bus.pc_ld !== 1'b1) $display("FAIL call_pc_ld got=%b exp=1", bus.pc_ld); else n_pass++;
      n_checks++; if (bus.ras_depth !== 4'd1) $display("FAIL call_depth got=%0d exp=1", bus.ras_depth); else n_pass++;
      drive_op(1'b1, OP_RET, 10'h200, 10'h000);
      n_checks++; if (bus.next_pc !== 10'h011) $display("FAIL ret_next_pc got=%h exp=011", bus.next_pc); else n_pass++;
      n_checks++; if (bus.pc_ld !== 1'b1) $display("FAIL ret_pc_ld got=%b exp=1", bus.pc_ld); else n_pass++;
      n_checks++; if (bus.ras_depth !== 4'd0) $display("FAIL ret_depth got=%0d exp=0", bus.ras_depth); else n_pass++;
      n_checks++; if (bus.ras_empty !== 1'b1) $display("FAIL ret_empty got=%b exp=1", bus.ras_empty); else n_pass++;
   endtask

   task automatic test_int();
      do_reset();
      drive_op(1'b1, OP_INT, 10'h055, 10'h0F0);
      n_checks++; if (bus.next_pc !== 10'h3FF) $display("FAIL int_next_pc got=%h exp=3ff", bus.next_pc); else n_pass++;
      n_checks++; if (bus.ras_depth !== 4'd1) $display("FAIL int_depth got=%0d exp=1", bus.ras_depth); else n_pass++;
      drive_op(1'b1, OP_RET, 10'h3FF, 10'h000);
      n_checks++; if (bus.next_pc !== 10'h055) $display("FAIL int_ret_next_pc got=%h exp=055", bus.next_pc); else n_pass++;
   endtask

   task automatic test_addr_wrap();
      do_reset();
      drive_op(1'b1, OP_CALL, 10'h3FF, 10'h100);
      drive_op(1'b1, OP_RET, 10'h100, 10'h000);
      n_checks++; if (bus.next_pc !== 10'h000) $display("FAIL addr_wrap_next_pc got=%h exp=000", bus.next_pc); else n_pass++;
      n_checks++; if (bus.pc_ld !== 1'b1) $display("FAIL addr_wrap_pc_ld got=%b exp=1", bus.pc_ld); else n_pass++;
   endtask

   task automatic test_overflow_underflow();
      logic [AW-1:0] br;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         br = AW'($urandom_range(0, 1023));
         drive_op(1'b1, OP_CALL, AW'(i), br);
         if (i == 7) begin
            n_checks++; if (bus.ras_full !== 1'b1) $display("FAIL ovf_full_at_8 got=%b exp=1", bus.ras_full); else n_pass++;
            n_checks++; if (bus.ras_err !== 1'b0) $display("FAIL ovf_err_at_8 got=%b exp=0", bus.ras_err); else n_pass++;
         end
      end
      n_checks++; if (bus.next_pc !== br) $display("FAIL ovf_next_pc got=%h exp=%h", bus.next_pc, br); else n_pass++;
      n_checks++; if (bus.pc_ld !== 1'b1) $display("FAIL ovf_pc_ld got=%b exp=1", bus.pc_ld); else n_pass++;
      n_checks++; if (bus.ras_full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", bus.ras_full); else n_pass++;
      n_checks++; if (bus.ras_depth !== 4'd8) $display("FAIL ovf_depth got=%0d exp=8", bus.ras_depth); else n_pass++;
`ifdef PC_NEXT_RAS_WRAP_EN
      n_checks++; if (bus.ras_err !== 1'b0) $display("FAIL ovf_err got=%b exp=0", bus.ras_err); else n_pass++;
`else
      n_checks++; if (bus.ras_err !== 1'b1) $display("FAIL ovf_err got=%b exp=1", bus.ras_err); else n_pass++;
`endif
      for (int i = 0; i < 8; i++) begin
         drive_op(1'b1, OP_RET, 10'h000, 10'h000);
         n_checks++; if (bus.next_pc !== exp_next) $display("FAIL ovf_ret_%0d got=%h exp=%h", i, bus.next_pc, exp_next); else n_pass++;
      end
      n_checks++; if (bus.ras_empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", bus.ras_empty); else n_pass++;
      do_reset();
      drive_op(1'b1, OP_RET, 10'h123, 10'h045);
      n_checks++; if (bus.next_pc !== 10'h000) $display("FAIL udf_next_pc got=%h exp=000", bus.next_pc); else n_pass++;
      n_checks++; if (bus.pc_ld !== 1'b1) $display("FAIL udf_pc_ld got=%b exp=1", bus.pc_ld); else n_pass++;
      n_checks++; if (bus.ras_err !== 1'b1) $display("FAIL udf_err got=%b exp=1", bus.ras_err); else n_pass++;
      n_checks++; if (bus.ras_depth !== 4'd0) $display("FAIL udf_depth got=%0d exp=0", bus.ras_depth); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) drive_op(1'b1, OP_CALL, AW'(10'h040 + i), AW'(10'h300 + i));
      rst             = 1'b1;
      bus.op_valid    = 1'b1;
      bus.op_code     = OP_CALL;
      bus.pc_cur      = 10'h077;
      bus.branch_addr = 10'h1EE;
      @(posedge clk);
      @(negedge clk);
      rst          = 1'b0;
      bus.op_valid = 1'b0;
      model_clear();
      n_checks++; if (bus.next_pc !== 10'h000) $display("FAIL rstmid_next_pc got=%h exp=000", bus.next_pc); else n_pass++;
      n_checks++; if (bus.pc_ld !== 1'b0) $display("FAIL rstmid_pc_ld got=%b exp=0", bus.pc_ld); else n_pass++;
      n_checks++; if (bus.ras_depth !== 4'd0) $display("FAIL rstmid_depth got=%0d exp=0", bus.ras_depth); else n_pass++;
      n_checks++; if (bus.ras_empty !== 1'b1) $display("FAIL rstmid_empty got=%b exp=1", bus.ras_empty); else n_pass++;
      n_checks++; if (bus.ras_err !== 1'b0) $display("FAIL rstmid_err got=%b exp=0", bus.ras_err); else n_pass++;
      drive_op(1'b0, OP_NONE, 10'h000, 10'h000);
      n_checks++; if (bus.pc_ld !== 1'b0) $display("FAIL rstmid_no_ld got=%b exp=0", bus.pc_ld); else n_pass++;
      drive_op(1'b1, OP_RET, 10'h000, 10'h000);
      n_checks++; if (bus.next_pc !== 10'h000) $display("FAIL rstmid_ret_next_pc got=%h exp=000", bus.next_pc); else n_pass++;
      n_checks++; if (bus.ras_err !== 1'b1) $display("FAIL rstmid_ret_err got=%b exp=1", bus.ras_err); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic       valid;
      logic [2:0] code;
      int         r;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         valid = ($urandom_range(0, 5) != 0);
         r = $urandom_range(0, 11);
         case (r)
            0, 1, 2: code = OP_CALL;
            3, 4, 5: code = OP_RET;
            6:       code = OP_JUMP;
            7:       code = OP_INT;
            8:       code = 3'd0;
            9:       code = 3'd5;
            10:      code = 3'd6;
            default: code = 3'd7;
         endcase
         drive_op(valid, code, AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)));
         n_checks++; if (bus.next_pc !== exp_next) $display("FAIL b2b_next_pc[%0d] got=%h exp=%h", i, bus.next_pc, exp_next); else n_pass++;
         n_checks++; if (bus.pc_ld !== exp_ld) $display("FAIL b2b_pc_ld[%0d] got=%b exp=%b", i, bus.pc_ld, exp_ld); else n_pass++;
         n_checks++; if (bus.ras_depth !== 4'(exp_q.size())) $display("FAIL b2b_depth[%0d] got=%0d exp=%0d", i, bus.ras_depth, exp_q.size()); else n_pass++;
         n_checks++; if (bus.ras_empty !== (exp_q.size() == 0)) $display("FAIL b2b_empty[%0d] got=%b", i, bus.ras_empty); else n_pass++;
         n_checks++; if (bus.ras_full !== (exp_q.size() == DEPTH)) $display("FAIL b2b_full[%0d] got=%b", i, bus.ras_full); else n_pass++;
         n_checks++; if (bus.ras_err !== exp_err) $display("FAIL b2b_err[%0d] got=%b exp=%b", i, bus.ras_err, exp_err); else n_pass++;
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.op_valid    = 1'b0;
      bus.op_code     = 3'd0;
      bus.pc_cur      = '0;
      bus.branch_addr = '0;
      model_clear();
      test_reset();
      test_jump();
      test_call_ret();
      test_int();
      test_addr_wrap();
      test_overflow_underflow();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
